// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: march-style self test initiator for the single-port RAM
// (EN/Address/Data_in -> Valid_out/Data_out).
// Phase 0 writes P(a) = SEED ^ a to every word and reads it back;
// phase 1 does the same with ~P(a). Pass/fail and the first failing
// address and data are reported and held until the next start.
// Build option: define MEM_BIST_ERRCNT_EN to add the err_count output and
// keep running after a mismatch (a timeout still ends the run).
module mem_bist_ctrl #(
    parameter int          ADDR_WIDTH = 4,
    parameter int          ADDR_DEPTH = 16,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] SEED       = 32'hA5A55A5A,
    parameter int          TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  EN,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  Valid_out,
    input  logic [DATA_WIDTH-1:0] Data_out
`ifdef MEM_BIST_ERRCNT_EN
    ,
    output logic [ADDR_WIDTH+1:0] err_count
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);
    localparam logic [CNT_W-1:0]      WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;
    logic [CNT_W-1:0]      wait_q, wait_d;
    logic                  en_q, en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  timeout_q, timeout_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
`ifdef MEM_BIST_ERRCNT_EN
    logic [ADDR_WIDTH+1:0] err_q, err_d;
`endif
    logic                  mism;
    logic                  adv;

    // Test word for address a: SEED ^ a in phase 0, its complement in phase 1.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic                  ph);
        logic [DATA_WIDTH-1:0] p;
        p = DATA_WIDTH'(SEED) ^ DATA_WIDTH'(a);
        return ph ? ~p : p;
    endfunction

    // Next-state, result capture and registered-output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        wait_d      = wait_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
`ifdef MEM_BIST_ERRCNT_EN
        err_d       = err_q;
`endif
        mism        = 1'b0;
        adv         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    timeout_d   = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
`ifdef MEM_BIST_ERRCNT_EN
                    err_d       = '0;
`endif
                end
            end

            S_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_READ_REQ;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end

            S_READ_REQ: begin
                state_d = S_READ_WAIT;
                wait_d  = '0;
            end

            S_READ_WAIT: begin
                if (Valid_out) begin
                    mism = (Data_out != pattern(addr_q, phase_q));
                    if (mism) begin
                        fail_d = 1'b1;
                        // Only the first failure of a run is recorded.
                        if (!fail_q) begin
                            fail_addr_d = addr_q;
                            fail_data_d = Data_out;
                        end
`ifdef MEM_BIST_ERRCNT_EN
                        err_d = err_q + 1'b1;
`endif
                    end
`ifdef MEM_BIST_ERRCNT_EN
                    adv = 1'b1;
`else
                    adv = !mism;
                    if (mism) begin
                        state_d = S_DONE;
                    end
`endif
                    if (adv) begin
                        if (addr_q != LAST_ADDR) begin
                            state_d = S_READ_REQ;
                            addr_d  = addr_q + 1'b1;
                        end else if (!phase_q) begin
                            state_d = S_WRITE;
                            phase_d = 1'b1;
                            addr_d  = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // RAM never answered: abandon the run whatever the build option.
                    state_d   = S_DONE;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                    if (!fail_q) begin
                        fail_addr_d = addr_q;
                        fail_data_d = '0;
                    end
`ifdef MEM_BIST_ERRCNT_EN
                    err_d = err_q + 1'b1;
`endif
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The verdict is settled on entry to DONE so it is visible with the done pulse.
        if (state_d == S_DONE) begin
            pass_d = ~fail_d;
        end

        en_d      = (state_d == S_WRITE);
        busy_d    = (state_d == S_WRITE) || (state_d == S_READ_REQ) || (state_d == S_READ_WAIT);
        done_d    = (state_d == S_DONE);
        data_in_d = (state_d == S_WRITE) ? pattern(addr_d, phase_d) : '0;
    end

    // State and output registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            wait_q      <= '0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_in_q   <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
`ifdef MEM_BIST_ERRCNT_EN
            err_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            wait_q      <= wait_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            data_in_q   <= data_in_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
`ifdef MEM_BIST_ERRCNT_EN
            err_q       <= err_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign EN        = en_q;
    assign Address   = addr_q;
    assign Data_in   = data_in_q;
`ifdef MEM_BIST_ERRCNT_EN
    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb_mem_bist_ctrl: drives mem_bist_ctrl against a behavioural single-port
// RAM with fault knobs (stuck bit, inverted read data, dropped read,
// extra read latency). Expected writes and run results are queued when a
// run is launched and compared as the DUT produces them.
module tb_mem_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass, fail, timeout;
    logic [3:0]  fail_addr;
    logic [31:0] fail_data;
    logic        EN;
    logic [3:0]  Address;
    logic [31:0] Data_in;
    logic        Valid_out;
    logic [31:0] Data_out;
`ifdef MEM_BIST_ERRCNT_EN
    logic [5:0]  err_count;
`endif

    mem_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .EN        (EN),
        .Address   (Address),
        .Data_in   (Data_in),
        .Valid_out (Valid_out),
        .Data_out  (Data_out)
`ifdef MEM_BIST_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- RAM model with fault knobs ----------------
    int lat     = 1;
    int stuck_a = -1;
    int inv_a   = -1;
    int inv_b   = -1;
    int drop_a  = -1;

    logic [31:0] mem [16];
    logic        rv;
    logic [31:0] rd;
    logic [3:0]  raddr;
    logic        pend;
    int          cnt;

    function automatic logic [31:0] rdval(input logic [3:0] a);
        if (int'(a) == inv_a || int'(a) == inv_b) return ~mem[a];
        return mem[a];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv    <= 1'b0;
            rd    <= 32'd0;
            pend  <= 1'b0;
            cnt   <= 0;
            raddr <= 4'd0;
        end else begin
            rv <= 1'b0;
            if (EN) mem[Address] <= (int'(Address) == stuck_a) ? (Data_in & ~32'd1) : Data_in;
            if (pend) begin
                if (cnt == 0) begin
                    rv   <= 1'b1;
                    rd   <= rdval(raddr);
                    pend <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (!rv && busy && !EN && int'(Address) != drop_a) begin
                if (lat <= 1) begin
                    rv <= 1'b1;
                    rd <= rdval(Address);
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 2;
                    raddr <= Address;
                end
            end
        end
    end

    assign Valid_out = rv;
    assign Data_out  = rd;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int          cyc;
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [3:0]  fa;
        logic [31:0] fd;
        int          ec;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];
    wr_t  wcur;

    function automatic logic [31:0] exp_pat(input int a, input int ph);
        logic [31:0] p;
        p = 32'hA5A55A5A ^ 32'(a);
        return (ph != 0) ? ~p : p;
    endfunction

    task automatic push_writes(input int nph);
        for (int ph = 0; ph < nph; ph++)
            for (int a = 0; a < 16; a++)
                wq.push_back('{4'(a), exp_pat(a, ph)});
    endtask

    // Every RAM write is matched against the next expected write.
    always @(negedge clk) begin
        if (rst && EN) begin
            if (wq.size() == 0) begin
                check_eq("unexpected_write", {28'd0, Address}, 64'hFFFF);
            end else begin
                wcur = wq.pop_front();
                check_eq("wr_addr", {60'd0, Address}, {60'd0, wcur.a});
                check_eq("wr_data", {32'd0, Data_in}, {32'd0, wcur.d});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"},
                 {busy, done, pass, fail, timeout, EN, fail_addr, Address},
                 64'd0);
        check_eq({tag, "_fdata"}, {32'd0, fail_data}, 64'd0);
        check_eq({tag, "_din"}, {32'd0, Data_in}, 64'd0);
`ifdef MEM_BIST_ERRCNT_EN
        check_eq({tag, "_errcnt"}, {58'd0, err_count}, 64'd0);
`endif
    endtask

    task automatic run_bist(input string tag, input int nph, input res_t r);
        res_t e;
        int   cyc;
        push_writes(nph);
        rq.push_back(r);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_done_seen"}, {63'd0, done}, 64'd1);
        e = rq.pop_front();
        check_eq({tag, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
        check_eq({tag, "_pass"}, {63'd0, pass}, {63'd0, e.pass});
        check_eq({tag, "_fail"}, {63'd0, fail}, {63'd0, e.fail});
        check_eq({tag, "_timeout"}, {63'd0, timeout}, {63'd0, e.tmo});
        check_eq({tag, "_fail_addr"}, {60'd0, fail_addr}, {60'd0, e.fa});
        check_eq({tag, "_fail_data"}, {32'd0, fail_data}, {32'd0, e.fd});
        check_eq({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
`ifdef MEM_BIST_ERRCNT_EN
        check_eq({tag, "_err_count"}, {58'd0, err_count}, 64'(e.ec));
`endif
        // start during the DONE cycle must not launch a new run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_idle_after"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_pass_held"}, {63'd0, pass}, {63'd0, e.pass});
        check_eq({tag, "_fail_held"}, {63'd0, fail}, {63'd0, e.fail});
        check_eq({tag, "_writes_left"}, 64'(wq.size()), 64'd0);
        wq.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        // clean run, zero-wait RAM
        run_bist("clean", 2, '{97, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 0});

        // bit 0 of address 5 stuck at 0
        stuck_a = 5;
`ifdef MEM_BIST_ERRCNT_EN
        run_bist("stuck", 2, '{97, 1'b0, 1'b1, 1'b0, 4'd5, 32'hA5A55A5E, 1});
`else
        run_bist("stuck", 1, '{29, 1'b0, 1'b1, 1'b0, 4'd5, 32'hA5A55A5E, 1});
`endif
        stuck_a = -1;

        // address 3 never answers
        drop_a = 3;
        run_bist("tmo", 1, '{32, 1'b0, 1'b1, 1'b1, 4'd3, 32'd0, 1});
        drop_a = -1;

        // read data arrives three cycles after the request
        lat = 3;
        run_bist("slow", 2, '{161, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 0});
        lat = 1;

        // start while busy is ignored; reset at write of address 7 aborts
        push_writes(1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(EN && Address == 4'd7) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("abort_reached_addr7", {63'd0, EN && Address == 4'd7}, 64'd1);
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b1;
        wq.delete();
        @(negedge clk);
        check_all_zero("abort_idle");
        run_bist("rerun", 2, '{97, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 0});

        // inverted read data at addresses 2 and 9
        inv_a = 2;
        inv_b = 9;
`ifdef MEM_BIST_ERRCNT_EN
        run_bist("inv", 2, '{97, 1'b0, 1'b1, 1'b0, 4'd2, 32'h5A5AA5A7, 4});
`else
        run_bist("inv", 1, '{23, 1'b0, 1'b1, 1'b0, 4'd2, 32'h5A5AA5A7, 1});
`endif
        inv_a = -1;
        inv_b = -1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
